wb_trace_buffer: RTL
====================

# wb_trace_buffer

Capture buffer that sits directly downstream of the `riscv` core's write-back port. It samples `WB_Data` whenever the core qualifies it, holds up to DEPTH words in a FIFO, and drains them through a ready/valid read port to a bench monitor or debug UART. It also keeps a running 32-bit write-back signature and a count of dropped words, so a whole program run can be checked from two registers.

## Interface

Parameters:
- DATA_W, 32, width of captured write-back data.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- CW = $clog2(DEPTH)+1, derived, width of `count`.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; the block is held in reset while low.
- clear  in  1  synchronous clear of FIFO, counters and signature.
- capture_en  in  1  gates capture; 0 ignores `wb_valid`.
- wb_valid  in  1  core write-back qualifier (register write this cycle).
- WB_Data  in  DATA_W  core write-back data.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DATA_W  FIFO head; forced to 0 when empty.
- count  out  CW  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow_cnt  out  16  dropped-word count; saturates at 16'hFFFF.
- signature  out  32  running write-back signature.

## Operation

- push = capture_en & wb_valid. pop = out_valid & out_ready.
- Storage is a register array with wr_ptr and rd_ptr of $clog2(DEPTH) bits that wrap naturally modulo DEPTH. Occupancy is an explicit `count` register.
- Push when not full: write mem[wr_ptr], wr_ptr+1.
- Push when full:
  - With a pop in the same cycle, the push is accepted and count is unchanged.
  - With no pop, the word is dropped and overflow_cnt increments (saturating). Pointers and count are unchanged.
- Pop when not empty: rd_ptr+1.
- Simultaneous push and pop when empty: only the push takes effect, because out_valid is 0.
- Count updates: push-only +1, pop-only -1, push+pop unchanged, dropped push unchanged.
- Signature update: on every push, whether accepted or dropped, signature <= {signature[30:0], signature[31]} ^ WB_Data[31:0], zero-extended if DATA_W < 32. It is independent of FIFO occupancy and out_ready.
- clear has priority over push and pop in the same cycle. It zeroes wr_ptr, rd_ptr, count, overflow_cnt and signature. The word presented that cycle is neither stored nor folded into the signature.
- capture_en = 0 blocks push only. Draining continues normally.
- There is no state machine beyond the FIFO control. Memory contents are not reset.

## Timing

- Reset values (reset low): out_valid 0, out_data 0, count 0, full 0, empty 1, overflow_cnt 0, signature 0, both pointers 0.
- Reset asserted mid-run discards all buffered data immediately, without waiting for a clock edge.
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on out_data with out_valid = 1 after edge N, when the FIFO was empty.
- out_valid, out_data, full, empty and count are functions of registered state only. There is no combinational path from wb_valid, WB_Data or out_ready to any output.
- Handshake: the consumer may hold out_ready high continuously. While out_valid = 1 and out_ready = 0, out_data is stable.
- Throughput: one push and one pop per cycle are sustained indefinitely at any occupancy from 1 to DEPTH.
- signature and overflow_cnt reflect a push on the cycle after the edge that samples it.

## Test plan

- Fill and drain: reset, then push 16 words 0x1..0x10 with out_ready = 0.
  - Required: full = 1, count = 16.
  - Then hold out_ready = 1: words come out 0x1..0x10 in order, then empty = 1 and out_data = 0.
- Overflow: with the FIFO full, 3 more pushes with out_ready = 0.
  - Required: overflow_cnt = 3, count = 16, head still 0x1.
  - Then force overflow_cnt near 16'hFFFF by pushing into the full FIFO and confirm it saturates at 16'hFFFF.
- Full with concurrent push+pop: FIFO full, push 0xAA and pop in the same cycle.
  - Required: count stays 16, overflow_cnt unchanged, 0xAA emerges last.
- Signature: after reset, push 0x00000001 then 0x80000000.
  - Required: signature = 0x00000001, then 0x80000002.
- Clear priority: FIFO holds 5 words, signature nonzero; assert clear with wb_valid = 1 and out_ready = 1 in the same cycle.
  - Required next cycle: count 0, empty 1, signature 0, overflow_cnt 0.
- Async reset mid-stream: drop reset low between clock edges with count = 7.
  - Required without waiting for an edge: out_valid 0, count 0.
  - After release, the first push reappears 1 cycle later.

Source files
------------

// File: rtl/wb_trace_buffer.sv
// wb_trace_buffer: FIFO capture of core write-back data with a ready/valid drain port,
// a running rotate-xor signature and a saturating dropped-word counter.
`default_nettype none

module wb_trace_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int CW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              capture_en,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic [15:0]       overflow_cnt,
  output logic [31:0]       signature
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     occ;
  logic [31:0]       sig_in;
  logic              push;
  logic              pop;
  logic              accept;
  logic              drop;

  generate
    if (DATA_W < 32) begin : g_sig_narrow
      assign sig_in = {{(32 - DATA_W){1'b0}}, WB_Data};
    end else if (DATA_W == 32) begin : g_sig_exact
      assign sig_in = WB_Data;
    end else begin : g_sig_wide
      assign sig_in = WB_Data[31:0];
    end
  endgenerate

  // Outputs depend only on registered state; out_data is zeroed while empty.
  assign count     = occ;
  assign full      = (occ == FULL_CNT);
  assign empty     = (occ == '0);
  assign out_valid = !empty;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  assign push   = capture_en & wb_valid;
  assign pop    = out_valid & out_ready;
  assign accept = push & (!full | pop);
  assign drop   = push & full & !pop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      overflow_cnt <= '0;
      signature    <= '0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occ          <= '0;
      overflow_cnt <= '0;
      signature    <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (drop && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
      // Dropped words still fold into the signature.
      if (push) signature <= {signature[30:0], signature[31]} ^ sig_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && !clear && accept) mem[wr_ptr] <= WB_Data;
  end

endmodule

`default_nettype wire
